// File: rtl/rng_pkg.sv
// rng_pkg: shared definitions for the obstacle random-number source.
//   LFSR_TAPS    - Galois feedback mask of the 16-bit LFSR
//   DEFAULT_SEED - reset seed, also substituted when a zero seed is loaded
//   state_t      - batch FSM states
//   lfsr_step    - one Galois shift of the 16-bit LFSR
package rng_pkg;

  localparam logic [15:0] LFSR_TAPS    = 16'hB400;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

  typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return (l >> 1) ^ (l[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/rng_lfsr.sv
// rng_lfsr: free-running 16-bit Galois LFSR with synchronous seed load.
// Ports:
//   clock      in  - rising-edge clock
//   reset      in  - asynchronous, active-low; returns the register to SEED
//   load       in  - replace the state with load_value instead of stepping
//   load_value in  - new seed; zero would lock the LFSR, so SEED is used instead
//   state      out - current LFSR contents
module rng_lfsr
  import rng_pkg::*;
#(
  parameter logic [15:0] SEED = DEFAULT_SEED
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        load,
  input  logic [15:0] load_value,
  output logic [15:0] state
);

  // Steps every cycle so that the timing of requests feeds the sequence.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= SEED;
    end else if (load) begin
      state <= (load_value == 16'h0000) ? SEED : load_value;
    end else begin
      state <= lfsr_step(state);
    end
  end

endmodule

// File: rtl/random_pool.sv
// random_pool: produces a batch of CHANNELS values in [0, RANGE) per request,
// none of which repeats any of the last NOREPEAT values emitted.
// Ports:
//   clock      in  - rising-edge clock
//   reset      in  - asynchronous, active-low
//   req        in  - batch request, sampled while idle
//   seed_load  in  - load seed_value into the LFSR and clear history (idle only)
//   seed_value in  - new seed, 0 selects SEED
//   busy       out - batch in progress, through the valid cycle
//   valid      out - one-cycle pulse, randoms holds a complete batch
//   randoms    out - channel k at [k*WIDTH +: WIDTH]
module random_pool
  import rng_pkg::*;
#(
  parameter int          WIDTH    = 4,
  parameter int          CHANNELS = 3,
  parameter int          RANGE    = 12,
  parameter int          NOREPEAT = 2,
  parameter logic [15:0] SEED     = DEFAULT_SEED
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      req,
  input  logic                      seed_load,
  input  logic [15:0]               seed_value,
  output logic                      busy,
  output logic                      valid,
  output logic [WIDTH*CHANNELS-1:0] randoms
);

  localparam int IDX_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  // Keeps the history arrays legal when exclusion is disabled.
  localparam int HDEPTH = (NOREPEAT > 0) ? NOREPEAT : 1;

  localparam logic [WIDTH:0]   RANGE_X  = (WIDTH+1)'(RANGE);
  localparam logic [WIDTH-1:0] LAST_VAL = WIDTH'(RANGE-1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHANNELS-1);

  state_t             state;
  logic [IDX_W-1:0]   idx;
  logic               first;
  logic [WIDTH-1:0]   cand_q;
  logic [WIDTH-1:0]   cand;
  logic [WIDTH-1:0]   folded;
  logic [WIDTH:0]     raw;
  logic               hit;
  logic [WIDTH-1:0]   hist_value [HDEPTH];
  logic [HDEPTH-1:0]  hist_valid;
  logic [15:0]        lfsr_state;
  logic               lfsr_load;
  logic               unused_lfsr_bits;

  // Seeds are only accepted while idle; a load during a batch is dropped.
  assign lfsr_load = (state == IDLE) && seed_load;

  rng_lfsr #(.SEED(SEED)) u_lfsr (
    .clock      (clock),
    .reset      (reset),
    .load       (lfsr_load),
    .load_value (seed_value),
    .state      (lfsr_state)
  );

  // Only the low WIDTH bits feed the fold; the rest only drive the shift.
  assign unused_lfsr_bits = ^lfsr_state;

  // Single subtraction suffices because 2*RANGE >= 2**WIDTH.
  always_comb begin
    raw = {1'b0, lfsr_state[WIDTH-1:0]};
    if (raw >= RANGE_X) begin
      raw = raw - RANGE_X;
    end
    folded = raw[WIDTH-1:0];
  end

  // After a hit, walk upward from the rejected value so each channel
  // resolves within NOREPEAT+1 cycles.
  always_comb begin
    if (first) begin
      cand = folded;
    end else if (cand_q == LAST_VAL) begin
      cand = '0;
    end else begin
      cand = cand_q + 1'b1;
    end
  end

  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < NOREPEAT; i++) begin
      if (hist_valid[i] && (hist_value[i] == cand)) begin
        hit = 1'b1;
      end
    end
  end

  // Batch FSM: one channel commit per miss cycle, history shifted on commit,
  // valid raised together with entry into DONE so it is a registered pulse.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      idx        <= '0;
      first      <= 1'b1;
      cand_q     <= '0;
      hist_valid <= '0;
      for (int i = 0; i < HDEPTH; i++) begin
        hist_value[i] <= '0;
      end
      randoms    <= '0;
      valid      <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (seed_load) begin
            hist_valid <= '0;
          end else if (req) begin
            idx   <= '0;
            first <= 1'b1;
            busy  <= 1'b1;
            state <= DRAW;
          end
        end
        DRAW: begin
          if (hit) begin
            cand_q <= cand;
            first  <= 1'b0;
          end else begin
            randoms[idx*WIDTH +: WIDTH] <= cand;
            for (int i = HDEPTH-1; i > 0; i--) begin
              hist_value[i] <= hist_value[i-1];
              hist_valid[i] <= hist_valid[i-1];
            end
            hist_value[0] <= cand;
            hist_valid[0] <= 1'b1;
            first         <= 1'b1;
            if (idx == LAST_IDX) begin
              state <= DONE;
              valid <= 1'b1;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        DONE: begin
          valid <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_random_pool.sv
// tb_random_pool: self-checking bench for random_pool.
// dut_a uses default parameters and is predicted exactly by a reference model
// (LFSR sequence plus a last-two exclusion list). dut_r forces a 3-value
// rotation, dut_z disables exclusion.
module tb_random_pool;

  localparam logic [15:0] SEED = 16'hACE1;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_a, req_r, req_z;
  logic        seed_load;
  logic [15:0] seed_value;
  logic        no_load;
  logic [15:0] no_seed;
  logic        busy_a, valid_a, busy_r, valid_r, busy_z, valid_z;
  logic [11:0] randoms_a, randoms_z;
  logic [5:0]  randoms_r;

  int          vectors = 0;
  int          miscompares = 0;

  logic [15:0] m;
  bit          a_idle;
  int          hist[$];
  int          obs[$];

  assign no_load = 1'b0;
  assign no_seed = 16'h0000;

  always #5 clock = ~clock;

  random_pool dut_a (
    .clock(clock), .reset(reset), .req(req_a), .seed_load(seed_load),
    .seed_value(seed_value), .busy(busy_a), .valid(valid_a), .randoms(randoms_a)
  );

  random_pool #(.WIDTH(2), .CHANNELS(3), .RANGE(3), .NOREPEAT(2)) dut_r (
    .clock(clock), .reset(reset), .req(req_r), .seed_load(no_load),
    .seed_value(no_seed), .busy(busy_r), .valid(valid_r), .randoms(randoms_r)
  );

  random_pool #(.NOREPEAT(0)) dut_z (
    .clock(clock), .reset(reset), .req(req_z), .seed_load(no_load),
    .seed_value(no_seed), .busy(busy_z), .valid(valid_z), .randoms(randoms_z)
  );

  function automatic logic [15:0] step(input logic [15:0] l);
    return (l >> 1) ^ (l[0] ? 16'hB400 : 16'h0000);
  endfunction

  function automatic int fold(input logic [15:0] l, input int width, input int range);
    int c;
    c = int'(l) & ((1 << width) - 1);
    if (c >= range) c = c - range;
    return c;
  endfunction

  function automatic bit in_hist(input int c);
    foreach (hist[i]) if (hist[i] == c) return 1'b1;
    return 1'b0;
  endfunction

  task automatic check_output(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Advance one edge, update the model LFSR of dut_a, sample 1 ns later.
  task automatic tick;
    @(posedge clock);
    if (!reset) m = SEED;
    else if (a_idle && seed_load) m = (seed_value == 16'h0000) ? SEED : seed_value;
    else m = step(m);
    #1;
  endtask

  // One batch on dut_a from an idle cycle; req_a is left high.
  task automatic apply_stimulus(input bit pulse_seed);
    logic [15:0] l;
    int          exp_vals[3];
    int          exp_lat;
    int          lat;
    bit          got;
    logic [11:0] exp_packed;
    req_a = 1'b1;
    tick;
    a_idle = 1'b0;
    check_output("busy_after_accept", busy_a, 1);
    l = m;
    exp_lat = 1;
    for (int k = 0; k < 3; k++) begin
      int c;
      c = fold(l, 4, 12);
      while (in_hist(c)) begin
        c = (c + 1) % 12;
        l = step(l);
        exp_lat++;
      end
      exp_vals[k] = c;
      hist.push_front(c);
      if (hist.size() > 2) void'(hist.pop_back());
      l = step(l);
      exp_lat++;
    end
    lat = 1;
    if (pulse_seed) begin
      seed_load  = 1'b1;
      seed_value = 16'h5555;
      tick;
      seed_load  = 1'b0;
      lat = 2;
    end
    got = 1'b0;
    for (int n = 0; n < 40 && !got; n++) begin
      if (valid_a) got = 1'b1;
      else begin
        tick;
        lat++;
      end
    end
    check_output("valid_seen", got, 1);
    check_output("latency", lat, exp_lat);
    check_output("latency_4_to_10", (lat >= 4 && lat <= 10), 1);
    check_output("busy_with_valid", busy_a, 1);
    exp_packed = '0;
    for (int k = 0; k < 3; k++) begin
      logic [3:0] v;
      bit rep;
      v = randoms_a[k*4 +: 4];
      exp_packed[k*4 +: 4] = 4'(exp_vals[k]);
      check_output("channel_value", v, exp_vals[k]);
      check_output("channel_in_range", (v < 4'd12), 1);
      rep = 1'b0;
      foreach (obs[j]) if (obs[j] == int'(v)) rep = 1'b1;
      check_output("no_recent_repeat", rep, 0);
      obs.push_front(int'(v));
      if (obs.size() > 2) void'(obs.pop_back());
    end
    tick;
    a_idle = 1'b1;
    check_output("valid_one_cycle", valid_a, 0);
    check_output("busy_idle", busy_a, 0);
    check_output("randoms_hold", randoms_a, exp_packed);
  endtask

  // One batch on dut_r (use_r) or dut_z from an idle cycle.
  task automatic run_other(input bit use_r, output int lat, output logic [11:0] vals);
    bit got;
    if (use_r) req_r = 1'b1;
    else req_z = 1'b1;
    tick;
    req_r = 1'b0;
    req_z = 1'b0;
    lat = 1;
    got = 1'b0;
    for (int n = 0; n < 40 && !got; n++) begin
      if (use_r ? valid_r : valid_z) got = 1'b1;
      else begin
        tick;
        lat++;
      end
    end
    check_output(use_r ? "rot_valid_seen" : "norep_valid_seen", got, 1);
    vals = use_r ? {6'b0, randoms_r} : randoms_z;
    tick;
  endtask

  initial begin
    int          lat;
    logic [11:0] vals;
    int          stream[$];

    reset = 1'b0;
    req_a = 1'b0;
    req_r = 1'b0;
    req_z = 1'b0;
    seed_load = 1'b0;
    seed_value = 16'h0000;
    a_idle = 1'b1;
    m = SEED;

    // Power-on reset
    repeat (2) tick;
    check_output("reset_busy", busy_a, 0);
    check_output("reset_valid", valid_a, 0);
    check_output("reset_randoms", randoms_a, 0);
    reset = 1'b1;
    check_output("lfsr_seed", dut_a.lfsr_state, 16'hACE1);
    tick;
    check_output("lfsr_first_step", dut_a.lfsr_state, 16'hE270);

    // 200 back-to-back requests with req held high
    for (int i = 0; i < 200; i++) apply_stimulus(1'b0);
    req_a = 1'b0;

    // req held through a batch, seed_load pulsed in DRAW
    apply_stimulus(1'b1);
    check_output("lfsr_not_reloaded", dut_a.lfsr_state, m);
    apply_stimulus(1'b0);
    req_a = 1'b0;

    // Nonzero seed load, then zero-seed load with a simultaneous req
    seed_load = 1'b1;
    seed_value = 16'h1234;
    tick;
    seed_load = 1'b0;
    hist.delete();
    obs.delete();
    check_output("lfsr_seed_1234", dut_a.lfsr_state, 16'h1234);
    check_output("busy_after_seed", busy_a, 0);
    apply_stimulus(1'b0);
    req_a = 1'b0;
    seed_load = 1'b1;
    seed_value = 16'h0000;
    req_a = 1'b1;
    tick;
    seed_load = 1'b0;
    req_a = 1'b0;
    hist.delete();
    obs.delete();
    check_output("lfsr_zero_seed", dut_a.lfsr_state, 16'hACE1);
    check_output("busy_req_ignored", busy_a, 0);
    tick;
    check_output("busy_stays_low", busy_a, 0);
    check_output("valid_stays_low", valid_a, 0);
    for (int i = 0; i < 3; i++) apply_stimulus(1'b0);
    req_a = 1'b0;

    // Reset in the middle of DRAW
    req_a = 1'b1;
    tick;
    req_a = 1'b0;
    tick;
    reset = 1'b0;
    #1;
    check_output("midreset_busy", busy_a, 0);
    check_output("midreset_valid", valid_a, 0);
    check_output("midreset_randoms", randoms_a, 0);
    check_output("midreset_lfsr", dut_a.lfsr_state, 16'hACE1);
    a_idle = 1'b1;
    hist.delete();
    obs.delete();
    tick;
    reset = 1'b1;
    check_output("release_lfsr", dut_a.lfsr_state, 16'hACE1);
    tick;
    check_output("release_lfsr_step", dut_a.lfsr_state, 16'hE270);
    for (int i = 0; i < 5; i++) apply_stimulus(1'b0);
    req_a = 1'b0;

    // Forced rotation: WIDTH=2, RANGE=3, NOREPEAT=2
    for (int b = 0; b < 10; b++) begin
      run_other(1'b1, lat, vals);
      check_output("rot_latency_max", (lat >= 4 && lat <= 10), 1);
      for (int k = 0; k < 3; k++) stream.push_back(int'(vals[k*2 +: 2]));
    end
    check_output("rot_second_differs", (stream[1] != stream[0]), 1);
    for (int i = 0; i < stream.size(); i++) begin
      check_output("rot_in_range", (stream[i] < 3), 1);
      if (i >= 2) check_output("rot_unique_third", stream[i], 3 - stream[i-1] - stream[i-2]);
    end

    // No exclusion: fixed best-case latency
    for (int b = 0; b < 10; b++) begin
      run_other(1'b0, lat, vals);
      check_output("norep_latency", lat, 4);
      for (int k = 0; k < 3; k++) check_output("norep_in_range", (vals[k*4 +: 4] < 4'd12), 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/random_pool.md
# random_pool

Parametrised obstacle random-number source for the game core. It generates a batch of `CHANNELS` values, each in `[0, RANGE)`, from a free-running 16-bit LFSR on every accepted request. No value in the batch may repeat any of the last `NOREPEAT` values emitted, whether in this batch or earlier ones. The game timing controller requests a batch at each spawn event; the obstacle spawner consumes `randoms` on `valid`.

## Interface
- `WIDTH`, default 4: bits per value.
- `CHANNELS`, default 3: values per batch.
- `RANGE`, default 12: exclusive upper bound per value. Constraints: `2*RANGE >= 2**WIDTH` and `RANGE <= 2**WIDTH`.
- `NOREPEAT`, default 2: depth of the exclusion history. Constraint: `0 <= NOREPEAT < RANGE`.
- `SEED`, default `16'hACE1`: LFSR reset and fallback seed. Must be nonzero.

Ports:
- `clock` in, 1: clock, rising edge.
- `reset` in, 1: asynchronous, active-low.
- `req` in, 1: batch request, level-sampled.
- `seed_load` in, 1: load `seed_value` into the LFSR.
- `seed_value` in, 16: new seed. A value of 0 loads `SEED`.
- `busy` out, 1: high from the cycle after acceptance until `valid` is deasserted.
- `valid` out, 1: one-cycle pulse; `randoms` is complete.
- `randoms` out, `WIDTH*CHANNELS`: channel k occupies `[k*WIDTH +: WIDTH]`. Stable from `valid` until the next batch commits channel 0.

## Operation
- **LFSR**
  - 16-bit Galois LFSR, taps `16'hB400`.
  - Steps every clock, including during a batch, so that request timing supplies entropy.
  - Next state: `(l>>1) ^ (l[0] ? 16'hB400 : 0)`.
- **Fold**
  - Take `c = lfsr[WIDTH-1:0]`.
  - If `c >= RANGE`, then `c = c - RANGE`.
- **History**
  - `NOREPEAT` entries, each a value plus a valid bit.
  - Every committed value is shifted in, and the oldest entry drops out.
  - Cleared (all valid bits 0) on reset and on an accepted `seed_load`.
  - Persists across batches.
- **FSM `IDLE`**
  - `seed_load=1`: load the LFSR, clear history, ignore `req`.
  - Otherwise, `req=1`: set `idx=0`, `first=1`, `busy=1`, go to `DRAW`.
- **FSM `DRAW`**
  - Candidate source:
    - `first=1`: fold of the current LFSR.
    - `first=0`: `cand_q+1`, wrapping from `RANGE-1` to 0.
  - Hit (candidate equals any valid history entry): `cand_q` = candidate, `first=0`, stay in `DRAW`.
  - Miss:
    - Write the candidate to channel `idx` and shift it into history.
    - Set `first=1`.
    - If `idx==CHANNELS-1`, go to `DONE`; otherwise increment `idx`.
  - Each channel resolves within `NOREPEAT+1` cycles.
- **FSM `DONE`**
  - `valid=1` and `busy=1` for one cycle, then go to `IDLE`.
- **Ignored inputs**
  - `req` and `seed_load` are ignored in `DRAW` and `DONE`. Requests are not queued.
- **Reset values**
  - `randoms=0`, `valid=0`, `busy=0`.
  - LFSR=`SEED`, history empty, state `IDLE`.
- **Reset mid-batch:** the batch is abandoned; all reset values apply immediately.

## Timing
- **Acceptance:** request accepted at rising edge t. `DRAW` occupies cycles t+1 onward.
- **Best-case latency:** with no hits, channel k commits at edge t+1+k and `valid` is high in cycle t+1+CHANNELS. Latency is `CHANNELS+1` cycles.
- **Hit cost:** each hit adds one cycle.
- **Worst-case latency:** `CHANNELS*(NOREPEAT+1)+1` cycles.
- **Earliest next acceptance:** the cycle after `valid`.
- **`randoms` updates:** only at channel commits. Earlier channels of a new batch overwrite the old batch before `valid`; consumers must sample on `valid`.

## Structure
- **Package `rng_pkg`:**
  - `LFSR_TAPS = 16'hB400`.
  - `DEFAULT_SEED = 16'hACE1`.
  - State enum `{IDLE, DRAW, DONE}`.
- **Sub-module `rng_lfsr`:**
  - 16-bit step and load.
  - Zero-seed substitution.
  - Ports: `clock`, `reset`, `load`, `load_value`, `state`.
- **Top module:** FSM, fold, history compare, channel writes.

## Test plan
- **Reset:** assert reset mid-`DRAW` -> same cycle `busy=0`, `valid=0`, `randoms=0`; after release, LFSR reads `16'hACE1`, next edge `16'hE270`.
- **Range:** defaults, 200 back-to-back requests -> every value < 12; `valid` exactly one cycle; latency between 4 and 10 cycles; no value equals either of the two previously emitted values.
- **Forced rotation:** `WIDTH=2`, `RANGE=3`, `NOREPEAT=2`, `CHANNELS=3`, 10 batches -> after the first two values, every emitted value is the unique one not among the last two, i.e. the output stream is strictly periodic with period 3.
- **Zero seed:** `seed_load` with `seed_value=0` in `IDLE` -> LFSR = `16'hACE1`, history cleared; a simultaneous `req` is ignored, `busy` stays 0.
- **Busy ignore:** `req` held high through a batch, and `seed_load` pulsed during `DRAW` -> exactly one `valid` per acceptance, a new batch starts the cycle after `DONE`, LFSR not reloaded.
- **No exclusion:** `NOREPEAT=0` -> latency exactly `CHANNELS+1` for every batch.
